// File: rtl/mac_t_reader.sv
// mac_t_reader: GMII egress framer draining one output queue (pointer + data FIFO).
// Define MAC_T_FCS_EN to add short-frame padding and CRC-32 FCS generation.
module mac_t_reader (
  input  logic        clk,
  input  logic        rstn,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_empty,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [15:0] tx_frame_cnt
);
  typedef enum logic [2:0] {
    IDLE, PTR_WAIT, PREAMBLE, SFD, DATA,
`ifdef MAC_T_FCS_EN
    PAD, FCS,
`endif
    IFG
  } state_t;
  state_t state_q, state_d;
  logic [10:0] n_q, n_d, cnt_q, cnt_d;
  logic [7:0] txd_d;
  logic en_d, last, unused_desc;
`ifdef MAC_T_FCS_EN
  logic [31:0] crc_q, crc_d;
`endif
  assign unused_desc = ^ptr_fifo_dout[15:11];
  assign gmii_tx_er = 1'b0;
  assign last = cnt_q == n_q - 11'd1;
  assign ptr_fifo_rd = rstn && state_q == IDLE && !ptr_fifo_empty;
  // Each byte is read two cycles ahead of its slot on gmii_txd
  assign data_fifo_rd = rstn && ((state_q == PREAMBLE && cnt_q == 11'd6) ||
                                 (state_q == SFD && n_q >= 11'd2) ||
                                 (state_q == DATA && {1'b0, cnt_q} + 12'd2 < {1'b0, n_q}));
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    case (state_q)
      IDLE:     state_d = ptr_fifo_empty ? IDLE : PTR_WAIT;
      PTR_WAIT: begin
        n_d = ptr_fifo_dout[10:0];
        state_d = ptr_fifo_dout[10:0] == 11'd0 ? IDLE : PREAMBLE;
      end
      PREAMBLE: state_d = cnt_q == 11'd6 ? SFD : PREAMBLE;
      SFD:      state_d = DATA;
`ifdef MAC_T_FCS_EN
      DATA:     state_d = !last ? DATA : n_q < 11'd60 ? PAD : FCS;
      PAD:      state_d = cnt_q == 11'd59 - n_q ? FCS : PAD;
      FCS:      state_d = cnt_q == 11'd3 ? IFG : FCS;
`else
      DATA:     state_d = last ? IFG : DATA;
`endif
      IFG:      state_d = cnt_q == 11'd9 ? IDLE : IFG;
      default:  state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? 11'd0 : cnt_q + 11'd1;
    en_d = !(state_d inside {IDLE, PTR_WAIT, IFG});
    // Output register is loaded with the byte belonging to the next state
    txd_d = state_d == PREAMBLE ? 8'h55 : state_d == SFD ? 8'hD5 : state_d == DATA ? data_fifo_dout : 8'h00;
`ifdef MAC_T_FCS_EN
    if (state_d == FCS) txd_d = ~crc_q[{cnt_d[1:0], 3'b000} +: 8];
`endif
  end
`ifdef MAC_T_FCS_EN
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {1'b0, r[31:1]} ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  always_comb crc_d = state_d == PREAMBLE ? 32'hFFFFFFFF :
                      (state_d == DATA || state_d == PAD) ? crc8(crc_q, txd_d) : crc_q;
  always_ff @(posedge clk) crc_q <= !rstn ? 32'hFFFFFFFF : crc_d;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      n_q <= '0;
      cnt_q <= '0;
      gmii_txd <= '0;
      gmii_tx_en <= 1'b0;
      tx_frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      gmii_txd <= txd_d;
      gmii_tx_en <= en_d;
      tx_frame_cnt <= tx_frame_cnt + {15'd0, state_d == IFG && state_q != IFG};
    end
  end
endmodule

// File: tb/tb_mac_t_reader.sv
// tb_mac_t_reader: queue-fed frame model checked cycle by cycle against mac_t_reader.
module tb_mac_t_reader;
  logic clk = 1'b0, rstn = 1'b0;
  logic ptr_fifo_rd, ptr_fifo_empty, data_fifo_rd, gmii_tx_en, gmii_tx_er;
  logic [15:0] ptr_fifo_dout, tx_frame_cnt;
  logic [7:0] data_fifo_dout, gmii_txd;
  int checks = 0, errors = 0, exp_frames = 0;
  int ptr_head = 0, ptr_tail = 0, data_head = 0, data_tail = 0;
  int obs_en, obs_drd;
  int gaps[$];
  logic [7:0] fb[$];
  logic [15:0] ptr_mem [0:255];
  logic [7:0] data_mem [0:32767];

  typedef struct packed { logic prd; logic drd; logic en; logic [7:0] txd; } obs_t;
  typedef struct { int n; int en; int drd; } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  mac_t_reader dut (
    .clk(clk), .rstn(rstn),
    .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(ptr_fifo_dout), .ptr_fifo_empty(ptr_fifo_empty),
    .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .tx_frame_cnt(tx_frame_cnt)
  );

  assign ptr_fifo_empty = ptr_head == ptr_tail;

  always @(posedge clk) begin
    if (!rstn) begin
      ptr_tail <= ptr_head;
      data_tail <= data_head;
    end else begin
      if (ptr_fifo_rd) begin
        ptr_fifo_dout <= ptr_mem[ptr_tail[7:0]];
        ptr_tail <= ptr_tail + 1;
      end
      if (data_fifo_rd) begin
        data_fifo_dout <= data_mem[data_tail[14:0]];
        data_tail <= data_tail + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef MAC_T_FCS_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return c;
  endfunction
`endif

  task automatic push_frame(input int n);
    fb = {};
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    ptr_mem[ptr_head[7:0]] = {5'($urandom), 11'(n)};
    ptr_head++;
    foreach (fb[i]) begin
      data_mem[data_head[14:0]] = fb[i];
      data_head++;
    end
  endtask

  // Queue every descriptor at once, predict the whole line, then compare each cycle
  task automatic run(input int lens[$]);
    obs_t e[$];
    obs_t got;
    int start, low;
    bit seen;
`ifdef MAC_T_FCS_EN
    logic [7:0] fr[$];
    logic [31:0] r, rv;
    logic [31:0] c;
`endif
    @(posedge clk); #1;
    foreach (lens[f]) begin
      push_frame(lens[f]);
      e.push_back({1'b1, 1'b0, 1'b0, 8'h00});
      e.push_back(11'd0);
      if (lens[f] == 0) continue;
      start = e.size();
      repeat (7) e.push_back({2'b00, 1'b1, 8'h55});
      e.push_back({2'b00, 1'b1, 8'hD5});
`ifdef MAC_T_FCS_EN
      while (fb.size() < 60) fb.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (fb[i]) c = crc_upd(c, fb[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
`endif
      foreach (fb[i]) e.push_back({2'b00, 1'b1, fb[i]});
      for (int i = start + 6; i < start + 6 + lens[f]; i++) e[i].drd = 1'b1;
      repeat (10) e.push_back(11'd0);
      exp_frames++;
    end
    repeat (4) e.push_back(11'd0);
    obs_en = 0;
    obs_drd = 0;
    gaps = {};
    low = 0;
    seen = 0;
    foreach (e[k]) begin
      @(negedge clk);
      got = {ptr_fifo_rd, data_fifo_rd, gmii_tx_en, gmii_txd};
      check($sformatf("cycle %0d", k), 32'(got), 32'(e[k]));
      obs_drd += int'(data_fifo_rd);
      if (gmii_tx_en) begin
        obs_en++;
        if (seen && low > 0) gaps.push_back(low);
        seen = 1;
        low = 0;
      end else if (seen) low++;
`ifdef MAC_T_FCS_EN
      if (gmii_tx_en) fr.push_back(gmii_txd);
      else if (fr.size() > 0) begin
        r = 32'hFFFFFFFF;
        for (int i = 8; i < fr.size(); i++) r = crc_upd(r, fr[i]);
        for (int i = 0; i < 32; i++) rv[i] = r[31-i];
        check("fcs residue", rv, 32'hC704DD7B);
        fr = {};
      end
`endif
    end
    check("frame count", 32'(tx_frame_cnt), 32'(exp_frames & 16'hFFFF));
    check("data reads exact", 32'(data_tail), 32'(data_head));
  endtask

  initial begin
    int l[$];
    bit ok;
`ifdef MAC_T_FCS_EN
    tbl[0] = '{64, 76, 64}; tbl[1] = '{9, 72, 9}; tbl[2] = '{1, 72, 1}; tbl[3] = '{59, 72, 59};
    tbl[4] = '{60, 72, 60}; tbl[5] = '{61, 73, 61}; tbl[6] = '{2047, 2059, 2047};
`else
    tbl[0] = '{68, 76, 68}; tbl[1] = '{1, 9, 1}; tbl[2] = '{2, 10, 2}; tbl[3] = '{59, 67, 59};
    tbl[4] = '{60, 68, 60}; tbl[5] = '{64, 72, 64}; tbl[6] = '{2047, 2055, 2047};
`endif
    repeat (3) @(negedge clk);
    check("reset ptr_rd", 32'(ptr_fifo_rd), 0);
    check("reset data_rd", 32'(data_fifo_rd), 0);
    check("reset tx_en", 32'(gmii_tx_en), 0);
    check("reset txd", 32'(gmii_txd), 0);
    check("reset tx_er", 32'(gmii_tx_er), 0);
    check("reset frame cnt", 32'(tx_frame_cnt), 0);
    rstn = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("idle empty", {21'd0, ptr_fifo_rd, data_fifo_rd, gmii_tx_en, gmii_txd}, 0);
    end
    check("idle frame cnt", 32'(tx_frame_cnt), 0);

    for (int v = 0; v < 7; v++) begin
      run('{tbl[v].n});
      check($sformatf("tx_en cycles N=%0d", tbl[v].n), obs_en, tbl[v].en);
      check($sformatf("data reads N=%0d", tbl[v].n), obs_drd, tbl[v].drd);
    end

    run('{100, 100, 100});
    check("gap count", gaps.size(), 2);
    foreach (gaps[i]) check("ifg length", gaps[i], 12);

    run('{0, 70});
`ifdef MAC_T_FCS_EN
    check("zero then 70 tx_en", obs_en, 82);
`else
    check("zero then 70 tx_en", obs_en, 78);
`endif
    check("zero then 70 reads", obs_drd, 70);

    for (int t = 0; t < 6; t++) begin
      l = {};
      repeat (1 + $urandom_range(3)) l.push_back($urandom_range(4) == 0 ? 0 : $urandom_range(1, 130));
      run(l);
    end

    @(posedge clk); #1;
    push_frame(68);
    obs_en = 0;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (gmii_tx_en) obs_en++;
      if (obs_en == 39) ok = 1;
    end
    check("reached byte 30", 32'(ok), 1);
    check("byte 30", 32'(gmii_txd), 32'(fb[30]));
    rstn = 1'b0;
    @(negedge clk);
    check("reset mid-frame", {21'd0, ptr_fifo_rd, data_fifo_rd, gmii_tx_en, gmii_txd}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("after reset quiet", {21'd0, ptr_fifo_rd, data_fifo_rd, gmii_tx_en, gmii_txd}, 0);
    end
    check("after reset frame cnt", 32'(tx_frame_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_t_reader.md
# mac_t_reader

Per-port egress transmitter that drains one post-switch output queue and drives a byte-wide GMII transmit interface. It pops a 16-bit frame descriptor from the queue's pointer FIFO, then reads exactly that many bytes from the queue's 8-bit data FIFO. It frames the bytes with preamble, SFD, optional padding and FCS, and enforces the inter-frame gap. One instance sits between each output queue's pointer/data FIFO read ports and the port PHY.

## Interface
- No parameters; widths fixed by the queue format.
- clk  in  1  single system clock; all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- ptr_fifo_rd  out  1  pop one descriptor; standard FIFO, dout valid the cycle after rd
- ptr_fifo_dout  in  16  descriptor; [10:0] frame byte length N, [15:11] ignored
- ptr_fifo_empty  in  1  pointer FIFO empty
- data_fifo_rd  out  1  pop one frame byte; dout valid the cycle after rd
- data_fifo_dout  in  8  frame byte, first byte = destination MAC MSB
- gmii_txd  out  8  registered transmit byte
- gmii_tx_en  out  1  registered transmit enable
- gmii_tx_er  out  1  held 0
- tx_frame_cnt  out  16  frames completed, wraps 0xFFFF->0

## Operation
- FSM states: IDLE, PTR_WAIT, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- IDLE: if !ptr_fifo_empty, assert ptr_fifo_rd for 1 cycle and go to PTR_WAIT.
- PTR_WAIT: latch N = ptr_fifo_dout[10:0].
  - N==0: descriptor discarded, no data reads, no IFG; return to IDLE.
  - Otherwise go to PREAMBLE.
- PREAMBLE: 7 bytes 0x55. SFD: 1 byte 0xD5.
- DATA: N bytes taken from data_fifo_dout, in FIFO order.
- Exactly N data_fifo_rd pulses per frame, on contiguous cycles, never more. The data FIFO is trusted non-empty once its descriptor is visible.
- 11-bit byte counter; the last byte is flagged when count==N-1.
- PAD (FCS build only): if N<60, emit 60-N bytes of 0x00.
- FCS (FCS build only): 4 bytes of CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) over data+pad, least significant byte first.
- IFG: gmii_tx_en=0 for 12 cycles minimum, then IDLE.
- tx_frame_cnt increments on the cycle the last byte of a frame (data, pad or FCS) is on gmii_txd.
- gmii_tx_en=1 exactly for preamble through last byte; no gaps inside a frame.
- gmii_txd=0x00 whenever gmii_tx_en=0.

## Timing
- Reset values: ptr_fifo_rd=0, data_fifo_rd=0, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, tx_frame_cnt=0, FSM=IDLE, CRC=0xFFFFFFFF.
- Reset mid-frame: the next cycle has gmii_tx_en=0 and no FIFO reads. The partial frame is abandoned; queue FIFOs share the reset.
- With ptr_fifo_rd at cycle T0:
  - T0+1: descriptor latched.
  - T0+2..T0+8: preamble on gmii_txd.
  - T0+9: SFD.
  - T0+10..T0+9+N: data bytes.
- data_fifo_rd asserted T0+8..T0+7+N: each byte is read 2 cycles before it appears (1 cycle FIFO latency + 1 cycle output register).
- Last frame byte at cycle L: gmii_tx_en=0 for L+1..L+12.
  - Earliest next ptr_fifo_rd is L+11.
  - Earliest next preamble is L+13.
- Back-to-back queued frames are sent at exactly this minimum spacing.
- ptr_fifo_empty is sampled only in IDLE. Empty asserting during a frame has no effect.

## Configuration
- MAC_T_FCS_EN defined: PAD and FCS states are built.
  - Descriptor N excludes FCS.
  - Transmitted frame length is max(N,60)+4.
- MAC_T_FCS_EN undefined: PAD, FCS and the CRC logic are absent.
  - N includes an FCS already stored in the data FIFO, and the bytes are forwarded verbatim.
  - No padding; the frame ends after N data bytes.

## Test plan
- Reset, empty=1 for 50 cycles -> no ptr_fifo_rd/data_fifo_rd, gmii_tx_en=0, tx_frame_cnt=0.
- FCS_EN, one descriptor N=64, bytes 0..63 -> ptr_fifo_rd at T0, 64 data_fifo_rd pulses T0+8..T0+71, then on gmii_txd: 7x0x55, 0xD5, bytes 0..63, 4 FCS bytes. tx_en high 76 cycles; CRC of data+FCS equals residue 0xC704DD7B; tx_frame_cnt=1.
- FCS_EN, N=9 -> 9 data bytes, 51 bytes 0x00, 4 FCS bytes. Exactly 9 data_fifo_rd pulses; FCS matches the bench CRC-32 model.
- Three queued descriptors N=100 -> tx_en low exactly 12 cycles between frames, tx_frame_cnt=3.
- Descriptor N=0 followed by N=70 -> first descriptor consumes no data and produces no tx_en. The second frame follows immediately with no IFG before it.
- FCS_EN undefined, N=68 -> 68 bytes forwarded verbatim after the SFD, no pad or FCS added. Also: rstn low at data byte 30 -> gmii_tx_en=0 the next cycle, no further reads.
